program_loader: RTL and testbench

- Serial instruction-stream transmitter that drives the OneBitProcessor load interface (its `en` and `inReg[0]` pins).
- Accepts parallel instruction words from a host or ROM over a valid/ready handshake.
- Shifts each word out MSB first, one bit per clock, with `ser_en` high only while a bit is valid.
- Signals completion once PROG_LENGTH words have been sent; the processor then runs with `en` low.

---
 rtl/program_loader.sv | 115 +++++++++++
 tb/tb_program_loader.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
`timescale 1ns/1ps
// program_loader: accepts instruction words over valid/ready and shifts them out MSB first
// on the OneBitProcessor load pins (en / inReg[0]), pulsing done after PROG_LENGTH words.
module program_loader #(
  parameter int INSTRUCTION_LENGTH = 13,
  parameter int PROG_LENGTH        = 16,
  parameter int IDX_W              = 4,
  parameter int BIT_W              = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          abort,
  input  logic                          word_valid,
  input  logic [INSTRUCTION_LENGTH-1:0] word_data,
  output logic                          word_ready,
  output logic [IDX_W-1:0]              word_index,
  output logic                          ser_en,
  output logic                          ser_data,
  output logic                          busy,
  output logic                          done
);

  typedef enum logic [1:0] {IDLE, WAIT_WORD, SHIFT, DONE} state_t;

  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(INSTRUCTION_LENGTH - 1);
  localparam logic [IDX_W-1:0] LAST_WORD = IDX_W'(PROG_LENGTH - 1);

  state_t                        state;
  logic [INSTRUCTION_LENGTH-1:0] shreg;
  logic [BIT_W-1:0]              bit_cnt;
  logic [IDX_W-1:0]              word_cnt;
  logic                          last_bit;
  logic                          last_word;

  assign last_bit   = (bit_cnt == LAST_BIT);
  assign last_word  = (word_cnt == LAST_WORD);
  assign word_index = word_cnt;

  // Ready depends only on state and counters so the host may make valid depend on ready.
  assign word_ready = (state == WAIT_WORD) ||
                      ((state == SHIFT) && last_bit && !last_word);

  // ser_data is loaded alongside shreg so it always mirrors the MSB about to leave.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      word_cnt <= '0;
      ser_en   <= 1'b0;
      ser_data <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          state    <= WAIT_WORD;
          word_cnt <= '0;
          busy     <= 1'b1;
        end
      end else if (abort) begin
        state    <= IDLE;
        ser_en   <= 1'b0;
        ser_data <= 1'b0;
        busy     <= 1'b0;
      end else begin
        case (state)
          WAIT_WORD: begin
            if (word_valid) begin
              shreg    <= word_data;
              bit_cnt  <= '0;
              ser_en   <= 1'b1;
              ser_data <= word_data[INSTRUCTION_LENGTH-1];
              state    <= SHIFT;
            end
          end
          SHIFT: begin
            if (!last_bit) begin
              shreg    <= {shreg[INSTRUCTION_LENGTH-2:0], 1'b0};
              bit_cnt  <= bit_cnt + BIT_W'(1);
              ser_data <= shreg[INSTRUCTION_LENGTH-2];
            end else if (last_word) begin
              shreg    <= '0;
              ser_en   <= 1'b0;
              ser_data <= 1'b0;
              done     <= 1'b1;
              state    <= DONE;
            end else if (word_valid) begin
              shreg    <= word_data;
              bit_cnt  <= '0;
              word_cnt <= word_cnt + IDX_W'(1);
              ser_data <= word_data[INSTRUCTION_LENGTH-1];
            end else begin
              shreg    <= '0;
              word_cnt <= word_cnt + IDX_W'(1);
              ser_en   <= 1'b0;
              ser_data <= 1'b0;
              state    <= WAIT_WORD;
            end
          end
          DONE: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
`timescale 1ns/1ps
// tb_program_loader: scoreboard bench; every accepted word pushes its 13 bits MSB first,
// and each ser_en cycle pops one and compares ser_data (plus word_index on a word's first bit).
module tb_program_loader;

  localparam int IL = 13;
  localparam int PL = 16;

  typedef struct {
    logic b;
    int   w;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset, start, abort, word_valid;
  logic [IL-1:0] word_data;
  logic          word_ready, ser_en, ser_data, busy, done;
  logic [3:0]    word_index;

  logic          start1, valid1;
  logic [IL-1:0] data1;
  logic          ready1, en1, sd1, busy1, done1;
  logic [0:0]    idx1;

  always #5 clk = ~clk;

  program_loader #(.INSTRUCTION_LENGTH(IL), .PROG_LENGTH(PL), .IDX_W(4), .BIT_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .word_valid(word_valid),
    .word_data(word_data), .word_ready(word_ready), .word_index(word_index),
    .ser_en(ser_en), .ser_data(ser_data), .busy(busy), .done(done)
  );

  program_loader #(.INSTRUCTION_LENGTH(IL), .PROG_LENGTH(1), .IDX_W(1), .BIT_W(4)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .abort(1'b0), .word_valid(valid1),
    .word_data(data1), .word_ready(ready1), .word_index(idx1),
    .ser_en(en1), .ser_data(sd1), .busy(busy1), .done(done1)
  );

  int checks = 0;
  int failures = 0;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  logic [IL-1:0] prog [PL];
  exp_t exp_q[$];
  exp_t mon_e;
  bit   mon_on = 0;
  bit   hs_pending = 0, exp_done_next = 0, prev_done = 0, chk_abort = 0, chk_reset = 0;
  int   accepted = 0, en_total = 0, cur_run = 0, last_run = 0, done_count = 0;
  int   cyc = 0, start_cyc = 0, first_en_cyc = 0;
  int   host_ptr = PL, stall_at = 3, stall_len = 0, stall_left = 0;
  int   abort_bit = -1, reset_bit = -1, start_bit = -1;

  // Monitor and scoreboard: all observation happens on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (mon_on) begin
      if (chk_reset) begin
        checkOutput("reset_ser_en", 32'(ser_en), 0);
        checkOutput("reset_ser_data", 32'(ser_data), 0);
        checkOutput("reset_busy", 32'(busy), 0);
        checkOutput("reset_done", 32'(done), 0);
        checkOutput("reset_ready", 32'(word_ready), 0);
        checkOutput("reset_index", 32'(word_index), 0);
        chk_reset = 0;
      end
      if (chk_abort) begin
        checkOutput("abort_ser_en", 32'(ser_en), 0);
        checkOutput("abort_busy", 32'(busy), 0);
        checkOutput("abort_ready", 32'(word_ready), 0);
        chk_abort = 0;
      end
      if (prev_done) checkOutput("busy_after_done", 32'(busy), 0);
      checkOutput("done", 32'(done), 32'(exp_done_next));
      if (done) begin
        done_count++;
        checkOutput("index_at_done", 32'(word_index), PL - 1);
      end
      prev_done = done;
      exp_done_next = 0;
      if (ser_en) begin
        if (en_total == 0) first_en_cyc = cyc;
        en_total++;
        cur_run++;
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_bit", 32'(ser_en), 0);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("ser_data", 32'(ser_data), 32'(mon_e.b));
          if (mon_e.w >= 0) checkOutput("word_index", 32'(word_index), mon_e.w);
          if (exp_q.size() == 0 && accepted == PL) exp_done_next = 1;
        end
      end else begin
        if (cur_run > 0) last_run = cur_run;
        cur_run = 0;
        checkOutput("ser_data_idle", 32'(ser_data), 0);
      end
      if (reset) begin
        exp_q.delete();
        exp_done_next = 0;
        chk_reset = 1;
      end else if (abort && busy) begin
        exp_q.delete();
        exp_done_next = 0;
        chk_abort = 1;
      end else begin
        if (start && !busy) begin
          accepted = 0;
          en_total = 0;
          start_cyc = cyc;
        end
        if (word_valid && word_ready) begin
          for (int i = IL - 1; i >= 0; i--) begin
            mon_e.b = word_data[i];
            mon_e.w = (i == IL - 1) ? accepted : -1;
            exp_q.push_back(mon_e);
          end
          accepted++;
          hs_pending = 1;
        end
      end
    end
  end

  // One cycle of host/driver activity, applied 1ns after the rising edge.
  task automatic applyStimulus(input bit st, input bit rst);
    @(posedge clk);
    #1;
    if (hs_pending) begin
      hs_pending = 0;
      host_ptr++;
    end
    reset = rst;
    start = st;
    abort = 1'b0;
    if (st) begin
      host_ptr = 0;
      stall_left = stall_len;
    end
    if (abort_bit >= 0 && ser_en && en_total == abort_bit) begin
      abort = 1'b1;
      abort_bit = -1;
    end
    if (reset_bit >= 0 && ser_en && en_total == reset_bit) begin
      reset = 1'b1;
      start = 1'b1;
      reset_bit = -1;
    end
    if (start_bit >= 0 && ser_en && en_total == start_bit) begin
      start = 1'b1;
      start_bit = -1;
    end
    if (host_ptr < PL) begin
      if (host_ptr == stall_at && stall_left > 0 && (stall_left < stall_len || word_ready)) begin
        if (stall_left < stall_len) begin
          checkOutput("ready_in_stall", 32'(word_ready), 1);
          checkOutput("en_in_stall", 32'(ser_en), 0);
        end
        word_valid = 1'b0;
        stall_left--;
      end else begin
        word_valid = 1'b1;
        word_data = prog[host_ptr];
      end
    end else begin
      word_valid = 1'b0;
    end
  endtask

  task automatic waitDone(input string name, input int budget);
    int n = 0;
    while (done_count == 0 && n < budget) begin
      applyStimulus(0, 0);
      n++;
    end
    applyStimulus(0, 0);
    applyStimulus(0, 0);
    checkOutput({name, "_done_count"}, done_count, 1);
    checkOutput({name, "_bits"}, en_total, IL * PL);
    checkOutput({name, "_queue_empty"}, exp_q.size(), 0);
  endtask

  exp_t q1[$];
  exp_t e1;
  bit   expd1, acc1;
  int   d1cnt;

  initial begin
    prog[0] = 13'h1FFF;
    prog[1] = 13'h0000;
    prog[2] = 13'h1555;
    prog[3] = 13'h0AAA;
    for (int i = 4; i < PL; i++) prog[i] = IL'($urandom_range(0, 8191));
    reset = 1'b1; start = 1'b0; abort = 1'b0; word_valid = 1'b0; word_data = '0;
    start1 = 1'b0; valid1 = 1'b0; data1 = '0;

    repeat (3) applyStimulus(0, 1);
    @(negedge clk);
    checkOutput("rst_ser_en", 32'(ser_en), 0);
    checkOutput("rst_ser_data", 32'(ser_data), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_done", 32'(done), 0);
    checkOutput("rst_ready", 32'(word_ready), 0);
    checkOutput("rst_index", 32'(word_index), 0);
    applyStimulus(0, 0);
    mon_on = 1;
    applyStimulus(0, 0);

    $display("[TB] back-to-back load");
    done_count = 0;
    applyStimulus(1, 0);
    waitDone("b2b", 400);
    checkOutput("b2b_run_length", last_run, IL * PL);
    checkOutput("b2b_latency", first_en_cyc - start_cyc, 2);

    $display("[TB] host stall before word 3");
    stall_len = 5;
    done_count = 0;
    applyStimulus(1, 0);
    waitDone("stall", 400);
    stall_len = 0;

    $display("[TB] abort mid-word");
    abort_bit = 2 * IL + 6;
    done_count = 0;
    applyStimulus(1, 0);
    for (int n = 0; n < 200 && abort_bit >= 0; n++) applyStimulus(0, 0);
    repeat (3) applyStimulus(0, 0);
    checkOutput("abort_point", en_total, 2 * IL + 7);
    checkOutput("abort_no_done", done_count, 0);
    checkOutput("abort_idle", 32'(busy), 0);
    applyStimulus(1, 0);
    waitDone("restart", 400);

    $display("[TB] reset mid-shift");
    reset_bit = 10 * IL + 9;
    done_count = 0;
    applyStimulus(1, 0);
    for (int n = 0; n < 300 && reset_bit >= 0; n++) applyStimulus(0, 0);
    applyStimulus(0, 0);
    applyStimulus(0, 0);
    checkOutput("reset_point", en_total, 10 * IL + 10);
    checkOutput("post_reset_ready", 32'(word_ready), 0);
    checkOutput("post_reset_busy", 32'(busy), 0);
    checkOutput("post_reset_no_done", done_count, 0);

    $display("[TB] start while busy");
    start_bit = 5 * IL + 3;
    done_count = 0;
    applyStimulus(1, 0);
    waitDone("busy_start", 400);
    applyStimulus(0, 0);

    $display("[TB] single-word build");
    data1 = 13'h1001;
    expd1 = 0;
    d1cnt = 0;
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0; valid1 = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      acc1 = 0;
      checkOutput("pl1_done", 32'(done1), 32'(expd1));
      if (done1) d1cnt++;
      expd1 = 0;
      if (en1) begin
        checkOutput("pl1_ready_in_shift", 32'(ready1), 0);
        if (q1.size() == 0) begin
          checkOutput("pl1_unexpected", 32'(en1), 0);
        end else begin
          e1 = q1.pop_front();
          checkOutput("pl1_bit", 32'(sd1), 32'(e1.b));
          if (q1.size() == 0) expd1 = 1;
        end
      end
      if (valid1 && ready1) begin
        for (int b = IL - 1; b >= 0; b--) begin
          e1.b = data1[b];
          e1.w = 0;
          q1.push_back(e1);
        end
        acc1 = 1;
      end
      @(posedge clk);
      #1;
      if (acc1) valid1 = 1'b0;
    end
    checkOutput("pl1_done_count", d1cnt, 1);
    checkOutput("pl1_queue_empty", q1.size(), 0);
    checkOutput("pl1_idle", 32'(busy1), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
